// File: rtl/connection_block.sv
// ---------------------------------------------------------------------------
// connection_block
//   Unidirectional routing connection block between two CLBs (clb0, clb1) on
//   one channel. Single and double tracks pass straight through in both
//   directions. A configured subset of tracks can instead be driven by CLB
//   outputs. Selected CLB input pins pick from channel, global or peer-CLB
//   lines. Carry chains are cross-wired between the two CLBs. Only the
//   configuration word is registered; every data path is combinational.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset (clears config)
//   i_cset, i_c         config load enable and configuration word (CW bits)
//   i_single0_in/1_in   singles entering from side 0 / side 1   (WS)
//   i_double0_in/1_in   doubles entering from side 0 / side 1   (WD)
//   o_single0_out/1_out singles leaving toward side 0 / side 1  (WS)
//   o_double0_out/1_out doubles leaving toward side 0 / side 1  (WD)
//   i_global            global lines                            (WG)
//   i_clb0/1_output     CLB output pins                         (CLBOUT)
//   i_clb0/1_cout       CLB carry outs                          (CARRY)
//   o_clb0/1_input      CLB input pins                          (CLBIN)
//   o_clb0/1_cin        CLB carry ins, cross-wired from peer cout
//
// Config word layout from bit 0, each field LSB-first:
//   CLBIN0 x SI0 (clb0 pins), CLBIN1 x SI1 (clb1 pins),
//   CLBOS x SO (single1_out), CLBOS x SO (single0_out),
//   CLBOD x SO (double1_out), CLBOD x SO (double0_out)
// ---------------------------------------------------------------------------
module connection_block #(
  parameter int WS         = 7,
  parameter int WD         = 6,
  parameter int WG         = 3,
  parameter int CLBIN      = 6,
  parameter int CLBIN0     = 2,
  parameter int CLBIN1     = 2,
  parameter int CLBOUT     = 2,
  parameter int CLBOUT0    = 2,
  parameter int CLBOUT1    = 2,
  parameter int CARRY      = 1,
  parameter int CLBOS      = 2,
  parameter int CLBOS_BIAS = 1,
  parameter int CLBOD      = 2,
  parameter int CLBOD_BIAS = 1,
  parameter int CLBX       = 1,
  localparam int NOC = CLBOUT0 + CLBOUT1,
  localparam int SO  = $clog2(NOC + 1),
  localparam int NI0 = (WS + WD) * 2 + WG + CLBX * CLBOUT1,
  localparam int SI0 = $clog2(NI0),
  localparam int NI1 = (WS + WD) * 2 + WG + CLBX * CLBOUT0,
  localparam int SI1 = $clog2(NI1),
  localparam int CW  = SO * 2 * (CLBOS + CLBOD) + SI0 * CLBIN0 + SI1 * CLBIN1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cset,
  input  logic [CW-1:0]     i_c,
  input  logic [WS-1:0]     i_single0_in,
  input  logic [WS-1:0]     i_single1_in,
  input  logic [WD-1:0]     i_double0_in,
  input  logic [WD-1:0]     i_double1_in,
  output logic [WS-1:0]     o_single0_out,
  output logic [WS-1:0]     o_single1_out,
  output logic [WD-1:0]     o_double0_out,
  output logic [WD-1:0]     o_double1_out,
  input  logic [WG-1:0]     i_global,
  input  logic [CLBOUT-1:0] i_clb0_output,
  input  logic [CLBOUT-1:0] i_clb1_output,
  input  logic [CARRY-1:0]  i_clb0_cout,
  input  logic [CARRY-1:0]  i_clb1_cout,
  output logic [CLBIN-1:0]  o_clb0_input,
  output logic [CLBIN-1:0]  o_clb1_input,
  output logic [CARRY-1:0]  o_clb0_cin,
  output logic [CARRY-1:0]  o_clb1_cin
);

  // Field base offsets inside the configuration word.
  localparam int OFF_C1 = SI0 * CLBIN0;
  localparam int OFF_S1 = OFF_C1 + SI1 * CLBIN1;
  localparam int OFF_S0 = OFF_S1 + SO * CLBOS;
  localparam int OFF_D1 = OFF_S0 + SO * CLBOS;
  localparam int OFF_D0 = OFF_D1 + SO * CLBOD;

  logic [CW-1:0]  r_cfg;
  logic [NOC-1:0] w_oc;
  logic [NI0-1:0] w_c0;
  logic [NI1-1:0] w_c1;

  // Reset wins over load; otherwise the word is held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg <= '0;
    end else if (i_cset) begin
      r_cfg <= i_c;
    end
  end

  // Output candidates for a muxable track: clb0 outputs first, then clb1.
  assign w_oc = {i_clb1_output[CLBOUT1-1:0], i_clb0_output[CLBOUT0-1:0]};

  // Which muxable slot (if any) owns a given single / double track index.
  function automatic int s_slot(input int j);
    int r;
    r = -1;
    for (int i = 0; i < CLBOS; i++) begin
      if ((i + CLBOS_BIAS * CLBOS) % WS == j) r = i;
    end
    return r;
  endfunction

  function automatic int d_slot(input int j);
    int r;
    r = -1;
    for (int i = 0; i < CLBOD; i++) begin
      if ((i + CLBOD_BIAS * CLBOD) % (WD / 2) == j) r = i;
    end
    return r;
  endfunction

  // sel 0 or out of range keeps the pass-through value.
  function automatic logic track_pick(input logic [SO-1:0] sel, input logic pass,
                                      input logic [NOC-1:0] oc);
    logic r;
    r = pass;
    for (int k = 0; k < NOC; k++) begin
      if (int'(sel) == k + 1) r = oc[k];
    end
    return r;
  endfunction

  // Out-of-range pin selects drive 0.
  function automatic logic pin_pick0(input logic [SI0-1:0] sel, input logic [NI0-1:0] cand);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NI0; k++) begin
      if (int'(sel) == k) r = cand[k];
    end
    return r;
  endfunction

  function automatic logic pin_pick1(input logic [SI1-1:0] sel, input logic [NI1-1:0] cand);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NI1; k++) begin
      if (int'(sel) == k) r = cand[k];
    end
    return r;
  endfunction

  // Single tracks.
  for (genvar j = 0; j < WS; j++) begin : g_single
    localparam int SL = s_slot(j);
    if (SL >= 0) begin : g_mux
      assign o_single1_out[j] = track_pick(r_cfg[OFF_S1 + SL * SO +: SO], i_single0_in[j], w_oc);
      assign o_single0_out[j] = track_pick(r_cfg[OFF_S0 + SL * SO +: SO], i_single1_in[j], w_oc);
    end else begin : g_pass
      assign o_single1_out[j] = i_single0_in[j];
      assign o_single0_out[j] = i_single1_in[j];
    end
  end

  // Double tracks: only the lower WD/2 can ever map to a slot.
  for (genvar j = 0; j < WD; j++) begin : g_double
    localparam int DL = d_slot(j);
    if (DL >= 0 && j < WD / 2) begin : g_mux
      assign o_double1_out[j] = track_pick(r_cfg[OFF_D1 + DL * SO +: SO], i_double0_in[j], w_oc);
      assign o_double0_out[j] = track_pick(r_cfg[OFF_D0 + DL * SO +: SO], i_double1_in[j], w_oc);
    end else begin : g_pass
      assign o_double1_out[j] = i_double0_in[j];
      assign o_double0_out[j] = i_double1_in[j];
    end
  end

  // CLB input candidate lists; entry 0 is the LSB of the concatenation.
  if (CLBX != 0) begin : g_cand_out
    assign w_c0 = {i_clb1_output[CLBOUT1-1:0], i_global, o_double0_out, o_double1_out,
                   o_single0_out, o_single1_out};
    assign w_c1 = {i_clb0_output[CLBOUT0-1:0], i_global, o_double0_out, o_double1_out,
                   o_single0_out, o_single1_out};
  end else begin : g_cand_in
    assign w_c0 = {i_global, i_double1_in, i_double0_in, i_single1_in, i_single0_in};
    assign w_c1 = {i_global, i_double1_in, i_double0_in, i_single1_in, i_single0_in};
  end

  for (genvar i = 0; i < CLBIN; i++) begin : g_pins
    if (i < CLBIN0) begin : g_p0
      assign o_clb0_input[i] = pin_pick0(r_cfg[i * SI0 +: SI0], w_c0);
    end else begin : g_z0
      assign o_clb0_input[i] = 1'b0;
    end
    if (i < CLBIN1) begin : g_p1
      assign o_clb1_input[i] = pin_pick1(r_cfg[OFF_C1 + i * SI1 +: SI1], w_c1);
    end else begin : g_z1
      assign o_clb1_input[i] = 1'b0;
    end
  end

  // Carry is pure wiring, independent of config and reset.
  assign o_clb0_cin = i_clb1_cout;
  assign o_clb1_cin = i_clb0_cout;

endmodule

// File: tb/tb_connection_block.sv
module tb_connection_block;

  localparam int CW = 44;
  localparam int OW = 40;

  logic          i_clk;
  logic          i_rst;
  logic          i_cset;
  logic [CW-1:0] i_c;
  logic [6:0]    i_single0_in, i_single1_in;
  logic [5:0]    i_double0_in, i_double1_in;
  logic [6:0]    o_single0_out, o_single1_out;
  logic [5:0]    o_double0_out, o_double1_out;
  logic [2:0]    i_global;
  logic [1:0]    i_clb0_output, i_clb1_output;
  logic [0:0]    i_clb0_cout, i_clb1_cout;
  logic [5:0]    o_clb0_input, o_clb1_input;
  logic [0:0]    o_clb0_cin, o_clb1_cin;

  logic [CW-1:0] m_cfg;
  logic [OW-1:0] exp_q[$];
  int            n_checks;
  int            n_pass;

  connection_block dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cset(i_cset), .i_c(i_c),
    .i_single0_in(i_single0_in), .i_single1_in(i_single1_in),
    .i_double0_in(i_double0_in), .i_double1_in(i_double1_in),
    .o_single0_out(o_single0_out), .o_single1_out(o_single1_out),
    .o_double0_out(o_double0_out), .o_double1_out(o_double1_out),
    .i_global(i_global),
    .i_clb0_output(i_clb0_output), .i_clb1_output(i_clb1_output),
    .i_clb0_cout(i_clb0_cout), .i_clb1_cout(i_clb1_cout),
    .o_clb0_input(o_clb0_input), .o_clb1_input(o_clb1_input),
    .o_clb0_cin(o_clb0_cin), .o_clb1_cin(o_clb1_cin)
  );

  // clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model at default parameters.
  // Packing: {clb1_cin, clb0_cin, clb1_input, clb0_input, d1o, d0o, s1o, s0o}
  function automatic logic [OW-1:0] model(input logic [CW-1:0] cfg);
    logic [6:0]  s0o, s1o;
    logic [5:0]  d0o, d1o;
    logic [5:0]  p0, p1;
    logic [3:0]  oc;
    logic [30:0] cand0, cand1;
    int          ts[2];
    int          td[2];
    int          s;
    ts[0] = 2; ts[1] = 3;
    td[0] = 2; td[1] = 0;
    oc  = {i_clb1_output, i_clb0_output};
    s1o = i_single0_in;
    s0o = i_single1_in;
    d1o = i_double0_in;
    d0o = i_double1_in;
    for (int i = 0; i < 2; i++) begin
      s = int'(cfg[20 + 3 * i +: 3]);
      if (s >= 1 && s <= 4) s1o[ts[i]] = oc[s - 1];
      s = int'(cfg[26 + 3 * i +: 3]);
      if (s >= 1 && s <= 4) s0o[ts[i]] = oc[s - 1];
      s = int'(cfg[32 + 3 * i +: 3]);
      if (s >= 1 && s <= 4) d1o[td[i]] = oc[s - 1];
      s = int'(cfg[38 + 3 * i +: 3]);
      if (s >= 1 && s <= 4) d0o[td[i]] = oc[s - 1];
    end
    cand0 = {i_clb1_output, i_global, d0o, d1o, s0o, s1o};
    cand1 = {i_clb0_output, i_global, d0o, d1o, s0o, s1o};
    p0 = '0;
    p1 = '0;
    for (int p = 0; p < 2; p++) begin
      s = int'(cfg[5 * p +: 5]);
      if (s < 31) p0[p] = cand0[s];
      s = int'(cfg[10 + 5 * p +: 5]);
      if (s < 31) p1[p] = cand1[s];
    end
    return {i_clb0_cout, i_clb1_cout, p1, p0, d1o, d0o, s1o, s0o};
  endfunction

  // One configuration edge; the bench tracks its own copy of the config.
  task automatic cfg_edge(input logic rst, input logic cset, input logic [CW-1:0] c);
    @(negedge i_clk);
    i_rst  = rst;
    i_cset = cset;
    i_c    = c;
    @(posedge i_clk);
    if (rst) m_cfg = '0;
    else if (cset) m_cfg = c;
    #1;
    i_rst  = 1'b0;
    i_cset = 1'b0;
  endtask

  task automatic rand_data();
    i_single0_in  = 7'($urandom());
    i_single1_in  = 7'($urandom());
    i_double0_in  = 6'($urandom());
    i_double1_in  = 6'($urandom());
    i_global      = 3'($urandom());
    i_clb0_output = 2'($urandom());
    i_clb1_output = 2'($urandom());
    i_clb0_cout   = 1'($urandom());
    i_clb1_cout   = 1'($urandom());
  endtask

  function automatic logic [CW-1:0] rand_cfg();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[CW-1:0];
  endfunction

  // Push expectation for the driven inputs, then pop and compare once settled.
  task automatic check_outputs(input string tag);
    logic [OW-1:0] exp;
    logic [OW-1:0] got;
    exp_q.push_back(model(m_cfg));
    #2;
    got = {o_clb1_cin, o_clb0_cin, o_clb1_input, o_clb0_input,
           o_double1_out, o_double0_out, o_single1_out, o_single0_out};
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_val({tag, ".s0o"}, 64'(got[6:0]),   64'(exp[6:0]));
      check_val({tag, ".s1o"}, 64'(got[13:7]),  64'(exp[13:7]));
      check_val({tag, ".d0o"}, 64'(got[19:14]), 64'(exp[19:14]));
      check_val({tag, ".d1o"}, 64'(got[25:20]), 64'(exp[25:20]));
      check_val({tag, ".clb0_in"}, 64'(got[31:26]), 64'(exp[31:26]));
      check_val({tag, ".clb1_in"}, 64'(got[37:32]), 64'(exp[37:32]));
      check_val({tag, ".cin"}, 64'(got[39:38]), 64'(exp[39:38]));
    end
  endtask

  initial begin
    logic [CW-1:0] c;
    n_checks = 0;
    n_pass   = 0;
    m_cfg    = '0;
    i_rst    = 1'b1;
    i_cset   = 1'b0;
    i_c      = '0;
    rand_data();

    // reset with a non-zero word pending: reset wins
    cfg_edge(1'b1, 1'b1, rand_cfg());
    cfg_edge(1'b1, 1'b0, rand_cfg());
    rand_data();
    check_outputs("reset");
    check_val("reset.pin0_direct", 64'(o_clb0_input[0]), 64'(i_single0_in[0]));
    check_val("reset.s1o_direct", 64'(o_single1_out), 64'(i_single0_in));

    // explicit all-zero load
    cfg_edge(1'b0, 1'b1, '0);
    rand_data();
    check_outputs("zero");
    check_val("zero.clb0_cin", 64'(o_clb0_cin), 64'(i_clb1_cout));
    check_val("zero.clb1_cin", 64'(o_clb1_cin), 64'(i_clb0_cout));

    // clb0 pin 0 selects
    c = '0; c[4:0] = 5'd5;
    cfg_edge(1'b0, 1'b1, c);
    rand_data();
    check_outputs("pin_sel5");
    check_val("pin_sel5.direct", 64'(o_clb0_input[0]), 64'(i_single0_in[5]));
    c = '0; c[4:0] = 5'd28;
    cfg_edge(1'b0, 1'b1, c);
    rand_data();
    i_global = 3'b100;
    check_outputs("pin_sel28a");
    check_val("pin_sel28.direct1", 64'(o_clb0_input[0]), 64'(1));
    i_global = 3'b011;
    check_outputs("pin_sel28b");
    check_val("pin_sel28.direct0", 64'(o_clb0_input[0]), 64'(0));
    c = '0; c[4:0] = 5'd30;
    cfg_edge(1'b0, 1'b1, c);
    rand_data();
    i_clb1_output = 2'b10;
    check_outputs("pin_sel30");
    check_val("pin_sel30.direct", 64'(o_clb0_input[0]), 64'(1));
    c = '0; c[4:0] = 5'd31; c[14:10] = 5'd31;
    cfg_edge(1'b0, 1'b1, c);
    rand_data();
    check_outputs("pin_sel31");
    check_val("pin_sel31.direct", 64'(o_clb0_input[0]), 64'(0));

    // single1_out track slot 0 (track 2) driven by clb1_output[0]
    c = '0; c[22:20] = 3'd3;
    cfg_edge(1'b0, 1'b1, c);
    rand_data();
    i_single0_in  = 7'b0000000;
    i_clb1_output = 2'b01;
    check_outputs("s1_sel3");
    check_val("s1_sel3.track2", 64'(o_single1_out[2]), 64'(1));
    rand_data();
    check_val("s1_sel3.track0", 64'(o_single1_out[0]), 64'(i_single0_in[0]));
    c[22:20] = 3'd0;
    cfg_edge(1'b0, 1'b1, c);
    check_outputs("s1_sel0");
    check_val("s1_sel0.track2", 64'(o_single1_out[2]), 64'(i_single0_in[2]));

    // double0_out slot 1 (track 0) driven by clb0_output[1]
    c = '0; c[43:41] = 3'd2;
    cfg_edge(1'b0, 1'b1, c);
    rand_data();
    i_double1_in  = 6'b111111;
    i_clb0_output = 2'b01;
    check_outputs("d0_sel2");
    check_val("d0_sel2.track0", 64'(o_double0_out[0]), 64'(0));
    check_val("d0_sel2.upper", 64'(o_double0_out[5:3]), 64'(i_double1_in[5:3]));

    // out-of-range track select keeps pass-through
    c = '0; c[28:26] = 3'd6; c[37:35] = 3'd7;
    cfg_edge(1'b0, 1'b1, c);
    rand_data();
    check_outputs("track_oor");

    // word changes with cset low are ignored, then reset restores pass-through
    cfg_edge(1'b0, 1'b1, rand_cfg());
    for (int i = 0; i < 4; i++) begin
      cfg_edge(1'b0, 1'b0, rand_cfg());
      rand_data();
      check_outputs("hold");
    end
    cfg_edge(1'b1, 1'b0, rand_cfg());
    rand_data();
    check_outputs("rst_again");
    check_val("rst_again.s0o", 64'(o_single0_out), 64'(i_single1_in));

    // random regression
    for (int i = 0; i < 100; i++) begin
      cfg_edge(1'b0, ($urandom_range(0, 3) != 0), rand_cfg());
      rand_data();
      check_outputs("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
